ptr_sync_multi: RTL
===================

PTR_SYNC_MULTI -- requirements
Module: ptr_sync_multi

Interface
REQ-001 SHALL have parameter PTR_WIDTH, default 8, meaning each pointer is PTR_WIDTH+1 bits (MSB is the wrap bit).
REQ-002 SHALL have parameter CHANNELS, default 2, meaning the number of independent pointers synchronised.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning the synchroniser depth; legal range 2..4.
REQ-004 SHALL have parameter ERR_CHECK, default 1, meaning gray-step checking is enabled; when 0, step_err is tied to 0.
REQ-005 SHALL have port dst_clk, input, 1 bit: the single clock; reset is asynchronous and active-low.
REQ-006 SHALL have port dst_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port src_ptr_gray, input, CHANNELS*(PTR_WIDTH+1) bits: gray pointers from a foreign domain, treated as asynchronous; channel c occupies bits [c*(PTR_WIDTH+1) +: PTR_WIDTH+1].
REQ-008 SHALL have port err_clr, input, 1 bit: synchronous clear of all step_err bits.
REQ-009 SHALL have port sync_ptr_gray, output, CHANNELS*(PTR_WIDTH+1) bits: synchroniser last-stage value per channel.
REQ-010 SHALL have port sync_ptr_bin, output, CHANNELS*(PTR_WIDTH+1) bits: registered binary equivalent per channel.
REQ-011 SHALL have port ptr_update, output, CHANNELS bits: one-cycle pulse per channel when sync_ptr_bin changes.
REQ-012 SHALL have port step_err, output, CHANNELS bits: sticky per-channel gray-violation flag.

Function
REQ-013 Each channel SHALL pass src_ptr_gray through a chain of SYNC_STAGES flops on dst_clk, with no logic between stages.
REQ-014 sync_ptr_gray SHALL be the last synchroniser stage; an input that is stable before edge k SHALL appear on sync_ptr_gray after edge k+SYNC_STAGES-1 (SYNC_STAGES edges of latency).
REQ-015 sync_ptr_bin SHALL be registered as the gray-to-binary conversion of sync_ptr_gray (bin[MSB]=g[MSB]; bin[i]=bin[i+1] XOR g[i]), giving SYNC_STAGES+1 edges of total latency.
REQ-016 ptr_update[c] SHALL be high for exactly the cycle in which sync_ptr_bin channel c differs from its value in the previous cycle, and low otherwise.
REQ-017 With ERR_CHECK=1, step_err[c] SHALL set in the same cycle as ptr_update[c] when the new and previous synchronised gray values differ in more than one bit.
REQ-018 step_err SHALL remain set until err_clr is sampled high; if err_clr and a new violation occur in the same cycle, step_err SHALL stay set (set wins).
REQ-019 Wrap-around (all-ones binary to zero, gray 10..0 to 00..0) SHALL be a single-bit step, SHALL pulse ptr_update, and SHALL NOT set step_err.
REQ-020 Channels SHALL be fully independent; simultaneous changes on several channels SHALL produce simultaneous ptr_update bits.
REQ-021 A stable input SHALL produce no ptr_update after the pipeline settles.

Reset
REQ-022 On dst_rst_n low, all synchroniser stages, sync_ptr_gray, sync_ptr_bin, ptr_update and step_err SHALL go to 0 immediately, with no clock required.
REQ-023 Reset release SHALL be synchronous-safe, and the first cycle after release SHALL NOT pulse ptr_update unless the synchronised value differs from 0.
REQ-024 Reset asserted mid-operation SHALL discard in-flight values; after release, the outputs SHALL re-acquire the current input with the latency of REQ-015.

Verification
REQ-025 Reset, then drive channel 0 gray 0x001 (bin 1) -> sync_ptr_gray = 0x001 after 2 edges, sync_ptr_bin = 0x001 and ptr_update[0] = 1 after 3 edges, ptr_update[0] = 0 on the next cycle.
REQ-026 Increment channel 0 through binary 0x1FF to 0x000 (gray 0x100 to 0x000), one step per 4 cycles -> every step pulses ptr_update[0], sync_ptr_bin tracks 0x1FF then 0x000, and step_err stays 0.
REQ-027 Jump channel 1 gray 0x000 to 0x003 -> step_err[1] = 1 with ptr_update[1]; step_err[0] stays 0; pulse err_clr -> step_err = 0 on the next edge.
REQ-028 Apply err_clr in the same cycle as a new violation on channel 1 -> step_err[1] remains 1.
REQ-029 Assert dst_rst_n low for 1 cycle while channel 0 is changing -> all outputs are 0 at once, then after release sync_ptr_bin equals the current input after 3 edges.
REQ-030 Repeat REQ-025 with SYNC_STAGES=3 and CHANNELS=4 -> the latency is 3 edges for gray and 4 edges for binary, and channels 1-3 show no ptr_update.

Source files
------------

// File: rtl/ptr_sync_multi.sv
// Multi-channel gray-pointer synchroniser: each lane carries an async gray pointer into
// dst_clk, re-registers it as binary, pulses on change and flags multi-bit gray steps.

module ptr_sync_lane #(
  parameter int W           = 9,
  parameter int SYNC_STAGES = 2,
  parameter bit ERR_EN      = 1'b1
) (
  input  logic         dst_clk,
  input  logic         dst_rst_n,
  input  logic [W-1:0] src_gray,
  input  logic         err_clr,
  output logic [W-1:0] gray,
  output logic [W-1:0] bin,
  output logic         upd,
  output logic         err
);
  localparam logic [W-1:0] ONE = W'(1);

  logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
  logic [W-1:0] bin_q, bin_d;
  logic [W-1:0] prev_gray, diff;
  logic         upd_q, upd_d;
  logic         err_q, err_d;
  logic         multi;

  // Plain shift chain: nothing may sit between metastability stages.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], src_gray};
  end

  always_comb begin
    bin_d = '0;
    for (int i = 0; i < W; i++) bin_d[i] = ^(sync_q[SYNC_STAGES-1] >> i);
  end

  // The gray value behind bin_q is recovered by re-encoding, so no extra gray history flop.
  always_comb begin
    prev_gray = bin_q ^ (bin_q >> 1);
    diff      = sync_q[SYNC_STAGES-1] ^ prev_gray;
    multi     = |(diff & (diff - ONE));
    upd_d     = (bin_d != bin_q);
    err_d     = ERR_EN & ((upd_d & multi) | (err_q & ~err_clr));
  end

  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      sync_q <= '0;
      bin_q  <= '0;
      upd_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      bin_q  <= bin_d;
      upd_q  <= upd_d;
      err_q  <= err_d;
    end
  end

  assign gray = sync_q[SYNC_STAGES-1];
  assign bin  = bin_q;
  assign upd  = upd_q;
  assign err  = err_q;
endmodule

module ptr_sync_multi #(
  parameter int PTR_WIDTH   = 8,
  parameter int CHANNELS    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CHECK   = 1
) (
  input  logic                              dst_clk,
  input  logic                              dst_rst_n,
  input  logic [CHANNELS*(PTR_WIDTH+1)-1:0] src_ptr_gray,
  input  logic                              err_clr,
  output logic [CHANNELS*(PTR_WIDTH+1)-1:0] sync_ptr_gray,
  output logic [CHANNELS*(PTR_WIDTH+1)-1:0] sync_ptr_bin,
  output logic [CHANNELS-1:0]               ptr_update,
  output logic [CHANNELS-1:0]               step_err
);
  localparam int W = PTR_WIDTH + 1;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    ptr_sync_lane #(
      .W          (W),
      .SYNC_STAGES(SYNC_STAGES),
      .ERR_EN     (ERR_CHECK != 0)
    ) u_lane (
      .dst_clk  (dst_clk),
      .dst_rst_n(dst_rst_n),
      .src_gray (src_ptr_gray[c*W +: W]),
      .err_clr  (err_clr),
      .gray     (sync_ptr_gray[c*W +: W]),
      .bin      (sync_ptr_bin[c*W +: W]),
      .upd      (ptr_update[c]),
      .err      (step_err[c])
    );
  end
endmodule
